// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and data_memory_unit.
// Owner encoding, FSM states and RISC-V load/store Func3 codes.
package dmem_arb_pkg;

   typedef enum logic [0:0] {
      S_CPU   = 1'b0,
      S_FORCE = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating count of cycles a DMA request has been refused.
// o_tc flags the last refusal before a forced DMA slot is due.
module dmem_arb_wait_cnt #(
   parameter  int MAX_WAIT = 8,
   localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_tc
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(MAX_WAIT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == CNT_TC);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory_unit between the core M stage (priority) and a DMA port.
// DMEM_ARB_STARVE_GUARD_EN compiles in the wait counter and the forced DMA slot.
//
// state   | meaning
// S_CPU   | core has priority, DMA served only when core is idle
// S_FORCE | one-cycle slot where a pending DMA request wins over the core
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [2:0]  cpu_func3,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_valid,
   output logic        dma_ready,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [2:0]  dma_func3,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_en_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_store_data,
   output logic [2:0]  mem_func3,
   input  logic [31:0] mem_load_data
);

   state_t      w_state;
   owner_t      w_owner;
   logic        r_dma_rvalid;
   logic [31:0] r_dma_rdata;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   state_t r_state;
   state_t w_state_nxt;
   logic   w_dma_refused;
   logic   w_tc;

   assign w_dma_refused = dma_valid & ~dma_ready;

   dmem_arb_wait_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_dma_refused),
      .i_clr (~dma_valid | dma_ready),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_CPU;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CPU:   if (w_tc && w_dma_refused) w_state_nxt = S_FORCE;
         S_FORCE: w_state_nxt = S_CPU;
         default: w_state_nxt = S_CPU;
      endcase
   end

   assign w_state = r_state;
`else
   assign w_state = S_CPU;
`endif

   always_comb begin
      w_owner = OWN_NONE;
      if (!reset) begin
         if (w_state == S_FORCE) begin
            if (dma_valid)    w_owner = OWN_DMA;
            else if (cpu_req) w_owner = OWN_CPU;
         end else begin
            if (cpu_req)        w_owner = OWN_CPU;
            else if (dma_valid) w_owner = OWN_DMA;
         end
      end
   end

   always_comb begin
      mem_en_write   = 1'b0;
      mem_address    = '0;
      mem_store_data = '0;
      mem_func3      = '0;
      cpu_rdata      = '0;
      cpu_stall      = 1'b0;
      dma_ready      = 1'b0;
      case (w_owner)
         OWN_CPU: begin
            mem_en_write   = cpu_we;
            mem_address    = cpu_addr;
            mem_store_data = cpu_wdata;
            mem_func3      = cpu_func3;
            cpu_rdata      = mem_load_data;
         end
         OWN_DMA: begin
            mem_en_write   = dma_we;
            mem_address    = dma_addr;
            mem_store_data = dma_wdata;
            mem_func3      = dma_func3;
            dma_ready      = 1'b1;
            cpu_stall      = cpu_req;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dma_rvalid <= 1'b0;
         r_dma_rdata  <= '0;
      end else begin
         r_dma_rvalid <= dma_ready & ~dma_we;
         if (dma_ready && !dma_we) r_dma_rdata <= mem_load_data;
      end
   end

   // Synchronous reset lands one edge late; mask the response so an in-flight read never shows.
   assign dma_rvalid = r_dma_rvalid & ~reset;
   assign dma_rdata  = reset ? '0 : r_dma_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed memory model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [2:0]  cpu_func3;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dma_valid, dma_ready, dma_we;
   logic [31:0] dma_addr, dma_wdata;
   logic [2:0]  dma_func3;
   logic        dma_rvalid;
   logic [31:0] dma_rdata;
   logic        mem_en_write;
   logic [31:0] mem_address, mem_store_data;
   logic [2:0]  mem_func3;
   logic [31:0] mem_load_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_func3      (cpu_func3),
      .cpu_rdata      (cpu_rdata),
      .cpu_stall      (cpu_stall),
      .dma_valid      (dma_valid),
      .dma_ready      (dma_ready),
      .dma_we         (dma_we),
      .dma_addr       (dma_addr),
      .dma_wdata      (dma_wdata),
      .dma_func3      (dma_func3),
      .dma_rvalid     (dma_rvalid),
      .dma_rdata      (dma_rdata),
      .mem_en_write   (mem_en_write),
      .mem_address    (mem_address),
      .mem_store_data (mem_store_data),
      .mem_func3      (mem_func3),
      .mem_load_data  (mem_load_data)
   );

   // Memory model: combinational read, write on the rising edge.
   logic [7:0] mem [0:255];
   logic [7:0] ma;
   logic [31:0] mw;

   always_comb begin
      ma = mem_address[7:0];
      mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
      case (mem_func3)
         LB:      mem_load_data = {{24{mw[7]}}, mw[7:0]};
         LH:      mem_load_data = {{16{mw[15]}}, mw[15:0]};
         LBU:     mem_load_data = {24'd0, mw[7:0]};
         LHU:     mem_load_data = {16'd0, mw[15:0]};
         default: mem_load_data = mw;
      endcase
   end

   always @(posedge clk) begin
      if (mem_en_write) begin
         case (mem_func3)
            SB: mem[ma] <= mem_store_data[7:0];
            SH: begin
               mem[ma]         <= mem_store_data[7:0];
               mem[ma + 8'd1]  <= mem_store_data[15:8];
            end
            default: begin
               mem[ma]         <= mem_store_data[7:0];
               mem[ma + 8'd1]  <= mem_store_data[15:8];
               mem[ma + 8'd2]  <= mem_store_data[23:16];
               mem[ma + 8'd3]  <= mem_store_data[31:24];
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_set(input logic req, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_func3 = f;
   endtask

   task automatic dma_set(input logic v, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f);
      dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d; dma_func3 = f;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1;
      cpu_set(1'b1, 1'b1, 32'h10, 32'h5555_5555, SW);
      dma_set(1'b1, 1'b1, 32'h20, 32'h6666_6666, SW);
      next_cycle();
      @(negedge clk);
      chk("rst_stall",  {31'd0, cpu_stall},    32'd0);
      chk("rst_ready",  {31'd0, dma_ready},    32'd0);
      chk("rst_we",     {31'd0, mem_en_write}, 32'd0);
      chk("rst_rvalid", {31'd0, dma_rvalid},   32'd0);
      chk("rst_rdata",  dma_rdata,             32'd0);
      next_cycle();
      reset = 1'b0;

      // CPU store then load
      cpu_set(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, SW);
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      @(negedge clk);
      chk("cpu_sw_stall", {31'd0, cpu_stall},    32'd0);
      chk("cpu_sw_we",    {31'd0, mem_en_write}, 32'd1);
      chk("cpu_sw_addr",  mem_address,           32'h10);
      chk("cpu_sw_data",  mem_store_data,        32'hDEAD_BEEF);
      next_cycle();
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0, LW);
      @(negedge clk);
      chk("cpu_lw_data",  cpu_rdata,             32'hDEAD_BEEF);
      chk("cpu_lw_stall", {31'd0, cpu_stall},    32'd0);
      chk("cpu_lw_we",    {31'd0, mem_en_write}, 32'd0);
      next_cycle();

      // DMA write then read
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      dma_set(1'b1, 1'b1, 32'h20, 32'h1234_5678, SW);
      @(negedge clk);
      chk("dma_wr_ready", {31'd0, dma_ready},    32'd1);
      chk("dma_wr_we",    {31'd0, mem_en_write}, 32'd1);
      chk("dma_wr_stall", {31'd0, cpu_stall},    32'd0);
      next_cycle();
      dma_set(1'b1, 1'b0, 32'h20, 32'h0, LW);
      @(negedge clk);
      chk("dma_rd_ready",  {31'd0, dma_ready},  32'd1);
      chk("dma_rd_rvalid0", {31'd0, dma_rvalid}, 32'd0);
      chk("dma_rd_cpurd",  cpu_rdata,           32'd0);
      next_cycle();
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      @(negedge clk);
      chk("dma_rd_rvalid1", {31'd0, dma_rvalid}, 32'd1);
      chk("dma_rd_rdata",   dma_rdata,           32'h1234_5678);
      chk("idle_addr",      mem_address,         32'd0);
      next_cycle();
      @(negedge clk);
      chk("dma_rd_rvalid2", {31'd0, dma_rvalid}, 32'd0);
      chk("dma_rd_hold",    dma_rdata,           32'h1234_5678);
      next_cycle();

      // Back-to-back DMA reads
      dma_set(1'b1, 1'b0, 32'h10, 32'h0, LW);
      next_cycle();
      dma_set(1'b1, 1'b0, 32'h20, 32'h0, LW);
      @(negedge clk);
      chk("b2b_rvalid_a", {31'd0, dma_rvalid}, 32'd1);
      chk("b2b_rdata_a",  dma_rdata,           32'hDEAD_BEEF);
      next_cycle();
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      @(negedge clk);
      chk("b2b_rvalid_b", {31'd0, dma_rvalid}, 32'd1);
      chk("b2b_rdata_b",  dma_rdata,           32'h1234_5678);
      next_cycle();

      // DMA byte store, CPU word load sees the merged word
      dma_set(1'b1, 1'b1, 32'h21, 32'h0000_00AB, SB);
      @(negedge clk);
      chk("sb_ready", {31'd0, dma_ready}, 32'd1);
      next_cycle();
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      cpu_set(1'b1, 1'b0, 32'h20, 32'h0, LW);
      @(negedge clk);
      chk("sb_cpu_lw", cpu_rdata, 32'h1234_AB78);
      next_cycle();

      // Conflict: CPU loads every cycle, DMA read pending from cycle 0
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0, LW);
      dma_set(1'b1, 1'b0, 32'h20, 32'h0, LW);
`ifdef DMEM_ARB_STARVE_GUARD_EN
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("grd_ready_c%0d", c), {31'd0, dma_ready}, 32'd0);
         chk($sformatf("grd_stall_c%0d", c), {31'd0, cpu_stall}, 32'd0);
         chk($sformatf("grd_cpurd_c%0d", c), cpu_rdata,          32'hDEAD_BEEF);
         next_cycle();
      end
      @(negedge clk);
      chk("grd_ready_c4", {31'd0, dma_ready}, 32'd1);
      chk("grd_stall_c4", {31'd0, cpu_stall}, 32'd1);
      chk("grd_addr_c4",  mem_address,        32'h20);
      next_cycle();
      @(negedge clk);
      chk("grd_ready_c5",  {31'd0, dma_ready},  32'd0);
      chk("grd_stall_c5",  {31'd0, cpu_stall},  32'd0);
      chk("grd_rvalid_c5", {31'd0, dma_rvalid}, 32'd1);
      chk("grd_rdata_c5",  dma_rdata,           32'h1234_AB78);
      next_cycle();
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      next_cycle();
`else
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         chk($sformatf("prio_ready_c%0d", c), {31'd0, dma_ready}, 32'd0);
         chk($sformatf("prio_stall_c%0d", c), {31'd0, cpu_stall}, 32'd0);
         next_cycle();
      end
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      @(negedge clk);
      chk("prio_ready_idle", {31'd0, dma_ready}, 32'd1);
      next_cycle();
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      @(negedge clk);
      chk("prio_rvalid", {31'd0, dma_rvalid}, 32'd1);
      chk("prio_rdata",  dma_rdata,           32'h1234_AB78);
      next_cycle();
`endif

      // Reset the cycle after a DMA read is accepted
      cpu_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      dma_set(1'b1, 1'b0, 32'h10, 32'h0, LW);
      @(negedge clk);
      chk("rr_accept", {31'd0, dma_ready}, 32'd1);
      next_cycle();
      reset = 1'b1;
      dma_set(1'b0, 1'b0, 32'h0, 32'h0, LW);
      cpu_set(1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, SW);
      @(negedge clk);
      chk("rr_rvalid", {31'd0, dma_rvalid},   32'd0);
      chk("rr_rdata",  dma_rdata,             32'd0);
      chk("rr_we",     {31'd0, mem_en_write}, 32'd0);
      chk("rr_stall",  {31'd0, cpu_stall},    32'd0);
      next_cycle();
      reset = 1'b0;
      cpu_set(1'b1, 1'b0, 32'h10, 32'h0, LW);
      @(negedge clk);
      chk("rr_mem_kept",   cpu_rdata,           32'hDEAD_BEEF);
      chk("rr_rvalid_aft", {31'd0, dma_rvalid}, 32'd0);
      chk("rr_rdata_aft",  dma_rdata,           32'd0);
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
